// File: rtl/soc_system_tc_mem_pkg.sv
// Shared constants and types for the TCM port-2 arbiter slice.
package soc_system_tc_mem_pkg;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int DEPTH   = 6144;
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_e;

  // One entry of the read-return pipeline: beat valid, owning master, out-of-range
  typedef struct packed {
    logic valid;
    logic id;
    logic oob;
  } rd_pipe_t;

endpackage

// File: rtl/soc_system_tc_mem_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the master favoured on contention.
module soc_system_tc_mem_rr_arb
  import soc_system_tc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr_q
);

  logic ptr_d;

  // Pointer flips once per completed burst
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~ptr_q;
  end

  // Pointer register, m0 favoured out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  // A lone requester wins outright; on contention the pointer decides
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/soc_system_tc_mem_arbiter.sv
// Shares TCM port 2 between two Avalon-MM burst masters (m0 = MAC DMA, m1 = HPS bridge).
// Arbitration only at burst boundaries; burst addresses generated here; the 1-cycle
// memory read latency is covered by a one-stage read-return pipeline.
module soc_system_tc_mem_arbiter #(
  parameter int ADDR_W  = soc_system_tc_mem_pkg::ADDR_W,
  parameter int DATA_W  = soc_system_tc_mem_pkg::DATA_W,
  parameter int DEPTH   = soc_system_tc_mem_pkg::DEPTH,
  parameter int BURST_W = soc_system_tc_mem_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [3:0]         m0_byteenable,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [3:0]         m1_byteenable,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [3:0]         mem_byteenable,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  input  logic [DATA_W-1:0]  mem_readdata,
  input  logic               err_clr,
  output logic               m0_oob_err,
  output logic               m1_oob_err
);
  import soc_system_tc_mem_pkg::*;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [BURST_W-1:0] bc_q, bc_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               id_q, id_d;
  rd_pipe_t           pipe_q, pipe_d;
  logic [1:0]         err_q, err_d;

  logic [1:0]         req, gnt;
  logic               rr_ptr, advance;
  logic [BURST_W-1:0] bc_in;
  logic [ADDR_W-1:0]  beat_addr;
  logic               beat_oob, issue, issue_oob;
  logic               g_write;
  logic [3:0]         g_be;
  logic [DATA_W-1:0]  g_wd;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  soc_system_tc_mem_rr_arb u_rr_arb (
    .clk     (clk),
    .rst     (reset),
    .req     (req),
    .advance (advance),
    .gnt     (gnt),
    .ptr_q   (rr_ptr)
  );

  // On contention the grant must follow the round-robin pointer
  a_rr_follows_ptr: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE && req == 2'b11) |-> (gnt[1] == rr_ptr));

  // State and datapath registers; reset abandons any burst and pending read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      bc_q    <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      pipe_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      bc_q    <= bc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      pipe_q  <= pipe_d;
      err_q   <= err_d;
    end
  end

  // Next state: grant latch in IDLE, beat counting in bursts, read pipe, sticky errors
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    bc_d    = bc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    advance = 1'b0;
    bc_in   = gnt[1] ? m1_burstcount : m0_burstcount;

    pipe_d.valid = (state_q == RD_BURST);
    pipe_d.id    = id_q;
    pipe_d.oob   = issue_oob;

    // Clear first so a same-cycle error still sets the flag
    err_d = err_clr ? 2'b00 : err_q;
    if (issue && issue_oob) err_d[id_q] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          id_d    = gnt[1];
          base_d  = gnt[1] ? m1_address : m0_address;
          bc_d    = (bc_in == '0) ? BURST_W'(1) : bc_in;
          cnt_d   = '0;
          state_d = (gnt[1] ? m1_write : m0_write) ? WR_BURST : RD_BURST;
        end
      end
      WR_BURST, RD_BURST: begin
        if (issue) begin
          cnt_d = cnt_q + BURST_W'(1);
          if (cnt_q == bc_q - BURST_W'(1)) begin
            state_d = IDLE;
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: waitrequest, memory command for the current beat, read return
  always_comb begin
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    issue          = 1'b0;
    issue_oob      = 1'b0;
    g_write        = id_q ? m1_write      : m0_write;
    g_be           = id_q ? m1_byteenable : m0_byteenable;
    g_wd           = id_q ? m1_writedata  : m0_writedata;
    beat_addr      = base_q + ADDR_W'(cnt_q);
    beat_oob       = {1'b0, beat_addr} >= (ADDR_W + 1)'(DEPTH);

    unique case (state_q)
      WR_BURST: begin
        if (id_q) m1_waitrequest = 1'b0;
        else      m0_waitrequest = 1'b0;
        if (g_write) begin
          issue          = 1'b1;
          issue_oob      = beat_oob;
          mem_address    = beat_addr;
          mem_byteenable = g_be;
          mem_writedata  = g_wd;
          mem_chipselect = ~beat_oob;
          mem_write      = ~beat_oob;
        end
      end
      RD_BURST: begin
        // Command is accepted on the first burst cycle only
        if (cnt_q == '0) begin
          if (id_q) m1_waitrequest = 1'b0;
          else      m0_waitrequest = 1'b0;
        end
        issue          = 1'b1;
        issue_oob      = beat_oob;
        mem_address    = beat_addr;
        mem_byteenable = '1;
        mem_chipselect = ~beat_oob;
      end
      default: ;
    endcase

    m0_readdatavalid = pipe_q.valid & ~pipe_q.id;
    m1_readdatavalid = pipe_q.valid &  pipe_q.id;
    m0_readdata      = (m0_readdatavalid && !pipe_q.oob) ? mem_readdata : '0;
    m1_readdata      = (m1_readdatavalid && !pipe_q.oob) ? mem_readdata : '0;
    m0_oob_err       = err_q[0];
    m1_oob_err       = err_q[1];
  end

endmodule
